// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: one-hot FSM states and the
// packed request register layout.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W    = 32;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_STRB_W    = 4;
  localparam int ARB_REQ_WIDTH = ARB_ADDR_W + 1 + ARB_DATA_W + ARB_STRB_W;
  localparam int ARB_CNT_W     = 3;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_INST_REQ  = 5'b00010,
    ST_INST_WAIT = 5'b00100,
    ST_DATA_REQ  = 5'b01000,
    ST_DATA_WAIT = 5'b10000
  } arb_state_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  wen;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_STRB_W-1:0] wstrb;
  } arb_req_t;

  // Fetches are always reads with no write payload.
  function automatic arb_req_t fetch_req(input logic [ARB_ADDR_W-1:0] pc);
    arb_req_t r;
    r      = '0;
    r.addr = pc;
    return r;
  endfunction

  function automatic arb_req_t data_req(input logic [ARB_ADDR_W-1:0] addr,
                                        input logic                  wen,
                                        input logic [ARB_DATA_W-1:0] wdata,
                                        input logic [ARB_STRB_W-1:0] wstrb);
    arb_req_t r;
    r.addr  = addr;
    r.wen   = wen;
    r.wdata = wdata;
    r.wstrb = wstrb;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants taken while a fetch waits; at_limit tells the
// arbiter that the fetch must win the next grant.
module mem_arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [ARB_CNT_W-1:0] LIMIT_C = ARB_CNT_W'(LIMIT);

  logic [ARB_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_C)) begin
      count <= count + ARB_CNT_W'(1);
    end
  end

  assign at_limit = (count == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, with data
// priority, fetch starvation protection and flush-killed fetch responses.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | port free; at most one requester handshake this cycle
//   INST_REQ  | fetch read presented to memory, held until Mem_Req_Ready
//   INST_WAIT | waiting for fetch data; dropped if kill is set
//   DATA_REQ  | load/store presented to memory, held until Mem_Req_Ready
//   DATA_WAIT | waiting for load data to hand to MEM
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic [31:0] inst_rdata,
  output logic        inst_rdata_valid,
  input  logic        inst_rdata_ready,

  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_rdata_valid,
  input  logic        data_rdata_ready,

  output logic [31:0] Address,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready
);

  arb_state_e state;
  arb_req_t   req_r;
  logic       kill;

  logic in_idle;
  logic in_req;
  logic in_inst_wait;
  logic in_data_wait;
  logic inst_pending;
  logic data_grant;
  logic inst_grant;
  logic at_limit;

  assign in_idle      = (state == ST_IDLE) && rst;
  assign in_req       = (state == ST_INST_REQ) || (state == ST_DATA_REQ);
  assign in_inst_wait = (state == ST_INST_WAIT);
  assign in_data_wait = (state == ST_DATA_WAIT);

  // A flushed fetch request does not count as pending for either grant or starvation.
  assign inst_pending = inst_req_valid && !inst_flush;
  assign data_grant   = in_idle && data_req_valid && !(inst_pending && at_limit);
  assign inst_grant   = in_idle && inst_pending && !data_grant;

  assign data_req_ready = data_grant;
  assign inst_req_ready = inst_grant;

  mem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (inst_grant || (data_grant && !inst_pending)),
    .inc      (data_grant && inst_pending),
    .at_limit (at_limit)
  );

  assign MemRead    = in_req && !req_r.wen;
  assign MemWrite   = in_req && req_r.wen;
  assign Address    = req_r.addr;
  assign Write_data = req_r.wdata;
  assign Write_strb = req_r.wstrb;

  assign inst_rdata       = Read_data;
  assign data_rdata       = Read_data;
  assign inst_rdata_valid = in_inst_wait && Read_data_Valid && !(kill || inst_flush);
  assign data_rdata_valid = in_data_wait && Read_data_Valid;

  // A killed fetch has no consumer, so the response is swallowed immediately.
  always_comb begin
    Read_data_Ready = 1'b0;
    if (in_inst_wait) begin
      Read_data_Ready = kill ? 1'b1 : inst_rdata_ready;
    end else if (in_data_wait) begin
      Read_data_Ready = data_rdata_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      req_r <= '0;
      kill  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          kill <= 1'b0;
          if (data_grant) begin
            req_r <= data_req(data_addr, data_wen, data_wdata, data_wstrb);
            state <= ST_DATA_REQ;
          end else if (inst_grant) begin
            req_r <= fetch_req(inst_addr);
            state <= ST_INST_REQ;
          end
        end
        ST_INST_REQ: begin
          if (inst_flush) begin
            kill <= 1'b1;
          end
          if (Mem_Req_Ready) begin
            state <= ST_INST_WAIT;
          end
        end
        ST_INST_WAIT: begin
          if (Read_data_Valid && Read_data_Ready) begin
            state <= ST_IDLE;
            kill  <= 1'b0;
          end else if (inst_flush) begin
            kill <= 1'b1;
          end
        end
        ST_DATA_REQ: begin
          if (Mem_Req_Ready) begin
            state <= req_r.wen ? ST_IDLE : ST_DATA_WAIT;
          end
        end
        ST_DATA_WAIT: begin
          if (Read_data_Valid && data_rdata_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          kill  <= 1'b0;
        end
      endcase
    end
  end

endmodule
